// File: rtl/simd_divider.sv
// simd_divider: LANES-wide iterative restoring radix-2 divider. All lanes run in
// lockstep, one quotient bit per cycle. Latency is fixed at WIDTH+2 cycles from
// pop to push, independent of data, op and zero divisors.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   valid / pop     operand-side handshake; pop is combinational, only in idle
//   ready / push    result-side handshake; transfer when push && ready
//   a, b            packed dividends / divisors, lane i at [i*WIDTH +: WIDTH]
//   op              op[0]: signed, op[1]: remainder (else quotient)
//   result          packed per-lane quotient or remainder
//   dz              per-lane divisor-was-zero flags, valid while push is high
module simd_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid,
    output logic                   pop,
    input  logic                   ready,
    output logic                   push,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    input  logic [1:0]             op,
    output logic [LANES*WIDTH-1:0] result,
    output logic [LANES-1:0]       dz
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

    state_e                   state_q;
    logic [CW-1:0]            cnt_q;
    logic                     rem_mode_q;
    logic                     push_q;
    logic [LANES*WIDTH-1:0]   result_q;
    logic [LANES-1:0]         dz_q;

    // dq_q starts as |a| and shifts out dividend bits while quotient bits shift in
    logic [WIDTH-1:0]         dq_q   [LANES];
    logic [WIDTH-1:0]         rem_q  [LANES];
    logic [WIDTH-1:0]         dvs_q  [LANES];
    logic [WIDTH-1:0]         a_q    [LANES];
    logic [LANES-1:0]         sq_q, sr_q, bz_q, ovf_q;

    logic [WIDTH-1:0]         lane_a [LANES];
    logic [WIDTH-1:0]         lane_b [LANES];
    logic [WIDTH-1:0]         mag_a  [LANES];
    logic [WIDTH-1:0]         mag_b  [LANES];
    logic [LANES-1:0]         sa, sb, bz_d, ovf_d;
    logic [WIDTH:0]           shifted [LANES];
    logic [WIDTH:0]           diff    [LANES];
    logic [WIDTH-1:0]         rem_nxt [LANES];
    logic [WIDTH-1:0]         dq_nxt  [LANES];
    logic [WIDTH-1:0]         q_fix   [LANES];
    logic [WIDTH-1:0]         r_fix   [LANES];
    logic [LANES*WIDTH-1:0]   fix_res;

    // Reset masks valid so nothing is consumed while held in reset
    assign pop    = rst && (state_q == StIdle) && valid;
    assign push   = push_q;
    assign result = result_q;
    assign dz     = dz_q;

    always_comb begin
        fix_res = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_a[i] = a[i*WIDTH +: WIDTH];
            lane_b[i] = b[i*WIDTH +: WIDTH];
            sa[i]     = op[0] & lane_a[i][WIDTH-1];
            sb[i]     = op[0] & lane_b[i][WIDTH-1];
            mag_a[i]  = sa[i] ? -lane_a[i] : lane_a[i];
            mag_b[i]  = sb[i] ? -lane_b[i] : lane_b[i];
            bz_d[i]   = (lane_b[i] == '0);
            ovf_d[i]  = op[0] && (lane_a[i] == {1'b1, {(WIDTH-1){1'b0}}}) && (lane_b[i] == '1);

            // One restoring step: a borrow (diff MSB set) means restore
            shifted[i] = {rem_q[i], dq_q[i][WIDTH-1]};
            diff[i]    = shifted[i] - {1'b0, dvs_q[i]};
            rem_nxt[i] = diff[i][WIDTH] ? shifted[i][WIDTH-1:0] : diff[i][WIDTH-1:0];
            dq_nxt[i]  = {dq_q[i][WIDTH-2:0], ~diff[i][WIDTH]};

            q_fix[i] = sq_q[i] ? -dq_q[i] : dq_q[i];
            r_fix[i] = sr_q[i] ? -rem_q[i] : rem_q[i];
            if (bz_q[i]) begin
                fix_res[i*WIDTH +: WIDTH] = rem_mode_q ? a_q[i] : '1;
            end else if (ovf_q[i]) begin
                fix_res[i*WIDTH +: WIDTH] = rem_mode_q ? '0 : a_q[i];
            end else begin
                fix_res[i*WIDTH +: WIDTH] = rem_mode_q ? r_fix[i] : q_fix[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rem_mode_q <= 1'b0;
            push_q     <= 1'b0;
            result_q   <= '0;
            dz_q       <= '0;
            sq_q       <= '0;
            sr_q       <= '0;
            bz_q       <= '0;
            ovf_q      <= '0;
            for (int i = 0; i < LANES; i++) begin
                dq_q[i]  <= '0;
                rem_q[i] <= '0;
                dvs_q[i] <= '0;
                a_q[i]   <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (valid) begin
                        rem_mode_q <= op[1];
                        sq_q       <= sa ^ sb;
                        sr_q       <= sa;
                        bz_q       <= bz_d;
                        ovf_q      <= ovf_d;
                        for (int i = 0; i < LANES; i++) begin
                            dq_q[i]  <= mag_a[i];
                            rem_q[i] <= '0;
                            dvs_q[i] <= mag_b[i];
                            a_q[i]   <= lane_a[i];
                        end
                        cnt_q   <= CW'(WIDTH);
                        state_q <= StIter;
                    end
                end
                StIter: begin
                    for (int i = 0; i < LANES; i++) begin
                        dq_q[i]  <= dq_nxt[i];
                        rem_q[i] <= rem_nxt[i];
                    end
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    result_q <= fix_res;
                    dz_q     <= bz_q;
                    push_q   <= 1'b1;
                    state_q  <= StDone;
                end
                StDone: begin
                    if (ready) begin
                        push_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_simd_divider.sv
// Self-checking bench for simd_divider (WIDTH=32, LANES=4): directed cases,
// backpressure, reset mid-operation and randomized operations checked against
// a plain-arithmetic reference model.
module tb_simd_divider;

    localparam int W = 32;
    localparam int L = 4;

    logic           clk;
    logic           rst;
    logic           valid;
    logic           pop;
    logic           ready;
    logic           push;
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
    logic [1:0]     op;
    logic [L*W-1:0] result;
    logic [L-1:0]   dz;

    int checks = 0;
    int errors = 0;

    simd_divider #(.WIDTH(W), .LANES(L)) dut (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .pop    (pop),
        .ready  (ready),
        .push   (push),
        .a      (a),
        .b      (b),
        .op     (op),
        .result (result),
        .dz     (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division semantics plus the zero-divisor and
    // MIN/-1 overrides.
    task automatic model(input logic [127:0] av, input logic [127:0] bv, input logic [1:0] opv,
                         output logic [127:0] res, output logic [3:0] dzv);
        logic [31:0] ai, bi, q, r;
        longint      sai, sbi;
        res = '0;
        dzv = '0;
        for (int i = 0; i < L; i++) begin
            ai = av[i*W +: W];
            bi = bv[i*W +: W];
            if (bi == 32'd0) begin
                q      = 32'hFFFF_FFFF;
                r      = ai;
                dzv[i] = 1'b1;
            end else if (opv[0] && ai == 32'h8000_0000 && bi == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else if (opv[0]) begin
                sai = longint'($signed(ai));
                sbi = longint'($signed(bi));
                q   = 32'(sai / sbi);
                r   = 32'(sai % sbi);
            end else begin
                q = ai / bi;
                r = ai % bi;
            end
            res[i*W +: W] = opv[1] ? r : q;
        end
    endtask

    // Caller sits just after a falling edge. hold_valid keeps valid high during
    // the backpressure window so the following pop can be observed.
    task automatic do_op(input logic [127:0] av, input logic [127:0] bv, input logic [1:0] opv,
                         input int rdy_delay, input bit hold_valid, input bit use_exp,
                         input logic [127:0] exp_res, input logic [3:0] exp_dz);
        logic [127:0] m_res;
        logic [3:0]   m_dz;
        logic [127:0] held;
        int           n;
        model(av, bv, opv, m_res, m_dz);
        a     = av;
        b     = bv;
        op    = opv;
        valid = 1'b1;
        #1;
        n = 0;
        while (!pop && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("pop_seen", {127'd0, pop}, 128'd1);
        @(negedge clk);
        valid = hold_valid;
        a     = ~av;
        b     = ~bv;
        op    = ~opv;
        n     = 1;
        while (!push && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", 128'(n), 128'(W + 2));
        check("result", result, m_res);
        check("dz", {124'd0, dz}, {124'd0, m_dz});
        if (use_exp) begin
            check("result_const", result, exp_res);
            check("dz_const", {124'd0, dz}, {124'd0, exp_dz});
        end
        held = result;
        for (int k = 0; k < rdy_delay; k++) begin
            @(negedge clk);
            check("push_held", {127'd0, push}, 128'd1);
            check("result_held", result, held);
            if (hold_valid) check("no_pop_busy", {127'd0, pop}, 128'd0);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("push_drop", {127'd0, push}, 128'd0);
        if (hold_valid) check("pop_after_xfer", {127'd0, pop}, 128'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [127:0] ra, rb;
        logic [127:0] sa_v, sb_v;
        rst   = 1'b0;
        valid = 1'b1;
        ready = 1'b0;
        a     = '0;
        b     = '0;
        op    = 2'b00;
        #2;
        check("rst_pop", {127'd0, pop}, 128'd0);
        check("rst_push", {127'd0, push}, 128'd0);
        check("rst_result", result, 128'd0);
        check("rst_dz", {124'd0, dz}, 128'd0);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Unsigned 100/7 in lane 0, other lanes 0/1
        do_op({32'd0, 32'd0, 32'd0, 32'd100}, {32'd1, 32'd1, 32'd1, 32'd7}, 2'b00, 0, 1'b0,
              1'b1, {96'd0, 32'd14}, 4'b0000);

        // Signed quotient and remainder
        sa_v = {32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'd7};
        sb_v = {32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd2};
        do_op(sa_v, sb_v, 2'b01, 0, 1'b0, 1'b1,
              {32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3, 32'd3}, 4'b0000);
        do_op(sa_v, sb_v, 2'b11, 0, 1'b0, 1'b1,
              {32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd1}, 4'b0000);

        // Divide by zero in lanes 0 and 2
        ra = {32'd10, 32'h8000_0000, 32'd9, 32'd9};
        rb = {32'd5, 32'd0, 32'd3, 32'd0};
        do_op(ra, rb, 2'b00, 0, 1'b0, 1'b1,
              {32'd2, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF}, 4'b0101);
        do_op(ra, rb, 2'b10, 0, 1'b0, 1'b1,
              {32'd0, 32'h8000_0000, 32'd0, 32'd9}, 4'b0101);

        // Signed overflow MIN / -1 in lane 0
        ra = {32'd0, 32'd0, 32'd0, 32'h8000_0000};
        rb = {32'd1, 32'd1, 32'd1, 32'hFFFF_FFFF};
        do_op(ra, rb, 2'b01, 0, 1'b0, 1'b1, {96'd0, 32'h8000_0000}, 4'b0000);
        do_op(ra, rb, 2'b11, 0, 1'b0, 1'b1, 128'd0, 4'b0000);

        // Backpressure: 10 cycles without ready, valid held high; next op pops
        // one cycle after the transfer
        do_op({32'd0, 32'd0, 32'd0, 32'd100}, {32'd1, 32'd1, 32'd1, 32'd7}, 2'b00, 10, 1'b1,
              1'b1, {96'd0, 32'd14}, 4'b0000);
        do_op({32'd40, 32'd30, 32'd20, 32'd10}, {32'd3, 32'd4, 32'd6, 32'd7}, 2'b10, 0, 1'b0,
              1'b1, {32'd1, 32'd2, 32'd2, 32'd3}, 4'b0000);

        // Reset during ITER cycle 15
        a     = {32'd0, 32'd0, 32'd0, 32'd100};
        b     = {32'd1, 32'd1, 32'd1, 32'd7};
        op    = 2'b00;
        valid = 1'b1;
        #1;
        check("mid_pop", {127'd0, pop}, 128'd1);
        @(negedge clk);
        valid = 1'b0;
        repeat (14) @(negedge clk);
        rst   = 1'b0;
        valid = 1'b1;
        #1;
        check("mid_rst_push", {127'd0, push}, 128'd0);
        check("mid_rst_result", result, 128'd0);
        check("mid_rst_dz", {124'd0, dz}, 128'd0);
        check("mid_rst_pop", {127'd0, pop}, 128'd0);
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            check("no_stale_push", {127'd0, push}, 128'd0);
        end
        do_op({32'd0, 32'd0, 32'd0, 32'd100}, {32'd1, 32'd1, 32'd1, 32'd7}, 2'b00, 0, 1'b0,
              1'b1, {96'd0, 32'd14}, 4'b0000);

        // Randomized operations against the model
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < L; i++) begin
                ra[i*W +: W] = pick();
                rb[i*W +: W] = pick();
            end
            do_op(ra, rb, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0,
                  1'b0, 128'd0, 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/simd_divider.md
# simd_divider

Parametrised successor to the single-lane divider: a LANES-wide SIMD iterative divider with signed/unsigned and quotient/remainder modes, per-lane divide-by-zero flags and a fixed, data-independent latency. It sits in the SIMD execution cluster behind the operand queue (valid/pop) and in front of the writeback queue (ready/push). It uses the same two-sided handshake as the existing scalar units. It computes all lanes in lockstep using restoring radix-2 division, one quotient bit per lane per cycle.

## Interface
- WIDTH, 32, bits per lane (≥2)
- LANES, 4, number of independent lanes (≥1)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- valid  in  1  operand queue holds an operation
- pop  out  1  operands consumed this cycle
- ready  in  1  writeback queue can accept a result
- push  out  1  result presented; transfer when push && ready
- a  in  LANES*WIDTH  dividends, lane i = a[i*WIDTH +: WIDTH]
- b  in  LANES*WIDTH  divisors, same packing
- op  in  2  op[0]=1 signed, 0 unsigned; op[1]=1 remainder, 0 quotient
- result  out  LANES*WIDTH  per-lane quotient or remainder, same packing
- dz  out  LANES  per-lane divisor-was-zero flag, valid while push=1

## Operation
- States: IDLE, ITER, FIX, DONE; 2-bit state, counter of $clog2(WIDTH+1) bits.
- IDLE: pop = valid (combinational, only in IDLE).
  - On pop, register per lane: |a|, |b| (two's-complement magnitude when op[0]=1), sign of quotient (sa^sb), sign of remainder (sa), b==0, the overflow case (signed, a=MIN, b=-1), and op.
  - Counter ← WIDTH. Next state: ITER.
- ITER: per lane, shift partial remainder left with the next dividend MSB. Subtract divisor; if no borrow, keep the difference and set quotient bit = 1, else restore. Decrement counter; ITER → FIX when the counter reaches 1 this cycle, giving exactly WIDTH ITER cycles.
- FIX: per lane, select quotient/remainder by op[1] and apply sign correction (negate quotient if its sign is 1, negate remainder if the dividend was negative). Then override:
  - b==0: quotient = all ones, remainder = a (original, unmodified), dz[i]=1.
  - Signed overflow: quotient = a (MIN), remainder = 0, dz[i]=0.
  - Register into result/dz. Next: DONE.
- DONE: push=1; result and dz held stable. On ready → IDLE next cycle (push drops). Without ready, stay in DONE indefinitely.
- pop never asserts outside IDLE; a and b are ignored outside the pop cycle.
- Lanes are fully independent; a divide-by-zero in one lane does not affect others.

## Timing
- Reset (rst=0, any time, asynchronous): state IDLE, counter 0, pop=0 (with valid masked), push=0, result=0, dz=0. Any in-flight operation is discarded without push. Deassertion is synchronised externally.
- Latency: pop in cycle T → push first high in cycle T+WIDTH+2. That is WIDTH cycles of ITER, 1 of FIX, DONE from T+WIDTH+2.
- Minimum initiation interval WIDTH+3 cycles (push&&ready at T+WIDTH+2 → IDLE at T+WIDTH+3 → earliest next pop).
- valid high during a busy period: no pop; the operation is taken the first IDLE cycle.
- ready high before DONE: no effect. push held ≥1 cycle; the transfer occurs in the first cycle with push && ready.
- Latency is independent of data, op, and zero divisors.

## Test plan
- Unsigned quotient (lane 0): a=100, b=7, op=00 → result=14, dz=0. Push exactly 34 cycles after pop at WIDTH=32.
- Signed (lanes 0–3, same op): op=01, a={-7,7,-7,7}, b={2,-2,-2,2} → {-3,-3,3,3}. Then op=11, same operands → {-1,1,-1,1}.
- Divide by zero (mixed lanes): b={0,3,0,5}, a={9,9,0x80000000,10}, op=00 → {0xFFFFFFFF,3,0xFFFFFFFF,2}, dz=4'b0101. With op=10 → lanes 0/2 return 9 and 0x80000000.
- Signed overflow: a=0x80000000, b=0xFFFFFFFF, op=01 → 0x80000000. With op=11 → 0, dz=0.
- Backpressure: ready=0 for 10 cycles after push rises → push and result stay constant, no pop despite valid=1. Ready=1 → one transfer; next pop one cycle later.
- Reset mid-operation: assert rst=0 at ITER cycle 15 → push=0, result=0 immediately. After release, a new 100/7 produces 14 with nominal latency and no stale push.
